// File: rtl/key_decoder.sv
// rtl/key_decoder.sv - word-code to character-stream decoder with writable dictionary
// Codes index a fixed-length dictionary; the selected word is emitted one byte per handshake.
module key_decoder #(
  parameter int WORD_LEN = 10,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [8*WORD_LEN-1:0] wr_data,
  input  logic [7:0]            code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  output logic [7:0]            char_out,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic                  word_end,
  output logic                  busy
);

  localparam int W         = 8 * WORD_LEN;
  localparam int NUM_WORDS = 2 ** ADDR_W;
  localparam int CW        = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [W-1:0]  dict [NUM_WORDS];
  logic [1:0]    state;
  logic          load_ph;
  logic [7:0]    code_q;
  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          in_range;
  logic [W-1:0]  entry;
  logic [W-1:0]  load_word;
  logic          last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) dict[i] <= '0;
    end else if (wr_en) begin
      dict[wr_addr] <= wr_data;
    end
  end

  assign in_range = ((code_q >> ADDR_W) == 8'd0);
  assign entry    = dict[code_q[ADDR_W-1:0]];

  // Out-of-range codes become '?', empty entries a single space.
  always_comb begin
    load_word = entry;
    if (!in_range)
      load_word = {8'h3F, {(W-8){1'b0}}};
    else if (entry[W-1 -: 8] == 8'h00)
      load_word = {8'h20, {(W-8){1'b0}}};
  end

  assign last       = (cnt == CW'(WORD_LEN - 1)) || (shreg[W-9 -: 8] == 8'h00);
  assign char_valid = (state == EMIT);
  assign char_out   = char_valid ? shreg[W-1 -: 8] : 8'h00;
  assign word_end   = char_valid && last;
  assign code_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // LOAD lasts two cycles: snapshot the entry, then hand over to EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      load_ph <= 1'b0;
      code_q  <= 8'h00;
      shreg   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (code_valid) begin
            code_q  <= code_in;
            load_ph <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (!load_ph) begin
            shreg   <= load_word;
            cnt     <= '0;
            load_ph <= 1'b1;
          end else begin
            load_ph <= 1'b0;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (char_ready) begin
            if (last) begin
              state <= IDLE;
            end else begin
              shreg <= shreg << 8;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_decoder.sv
// tb/tb_key_decoder.sv - scoreboard bench for key_decoder
// Reference model turns each accepted code into an expected character list.
module tb_key_decoder;

  localparam int WORD_LEN = 10;
  localparam int ADDR_W   = 4;
  localparam int NW       = 16;

  logic        clk = 0;
  logic        rst = 1;
  logic        wr_en = 0;
  logic [3:0]  wr_addr = 0;
  logic [79:0] wr_data = 0;
  logic [7:0]  code_in = 0;
  logic        code_valid = 0;
  logic        code_ready;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1;
  logic        word_end;
  logic        busy;

  key_decoder #(.WORD_LEN(WORD_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .word_end(word_end), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] c; bit last; } exp_t;
  exp_t exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int rmode = 0;
  int hs_cnt = 0;
  int we_cnt = 0;
  int last_hs_edge = -100;
  int acc_edge = 0;
  bit load_pending = 0;
  logic [7:0]  mcode;
  logic [79:0] mdict [NW];

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Expected text, built straight from the decoding rules.
  task automatic push_word(input logic [7:0] code, input logic [79:0] ent);
    exp_t e;
    int n;
    logic [7:0] b;
    if (int'(code) >= NW) begin
      e.c = 8'h3F; e.last = 1; exp_q.push_back(e);
    end else if (ent[79:72] == 8'h00) begin
      e.c = 8'h20; e.last = 1; exp_q.push_back(e);
    end else begin
      n = 0;
      for (int i = 0; i < WORD_LEN; i++) begin
        b = ent[79 - 8*i -: 8];
        if (b == 8'h00) break;
        e.c = b; e.last = 0; exp_q.push_back(e);
        n++;
      end
      exp_q[exp_q.size()-1].last = 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      load_pending = 0;
      for (int i = 0; i < NW; i++) mdict[i] = '0;
    end else begin
      if (load_pending) push_word(mcode, (int'(mcode) < NW) ? mdict[mcode[3:0]] : 80'h0);
      load_pending = 0;
      if (wr_en) mdict[wr_addr] = wr_data;
      if (code_valid && code_ready) begin
        load_pending = 1;
        mcode = code_in;
      end
    end
  end

  bit stalled_prev = 0;
  logic [7:0] prev_char;
  bit lat_armed = 0;
  bit end_pending = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled_prev = 0; lat_armed = 0; end_pending = 0;
    end else begin
      if (end_pending) chk("ready_after_last", code_ready && !busy, {busy, code_ready}, 32'h1);
      end_pending = 0;
      if (stalled_prev) chk("stall_hold", char_valid && char_out == prev_char, {char_valid, char_out}, {1'b1, prev_char});
      stalled_prev = char_valid && !char_ready;
      prev_char = char_out;
      if (lat_armed && char_valid) begin
        chk("latency", cyc == acc_edge + 2, cyc - acc_edge, 2);
        lat_armed = 0;
      end
      if (code_valid && code_ready) begin
        lat_armed = 1;
        acc_edge = cyc + 1;
      end
      if (busy) chk("ready_low_busy", !code_ready, code_ready, 0);
      if (char_valid && char_ready) begin
        hs_cnt++;
        if (word_end) begin
          we_cnt++;
          end_pending = 1;
          last_hs_edge = cyc + 1;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_char", 0, char_out, 0);
        end else begin
          e = exp_q.pop_front();
          chk("char", char_out == e.c, char_out, e.c);
          chk("word_end", word_end == e.last, word_end, e.last);
        end
      end
    end
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int pidx = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: char_ready = 1;
      1: begin char_ready = pat[pidx % 4]; pidx++; end
      default: char_ready = ($urandom % 4) != 0;
    endcase
  end

  task automatic wait_accept(output int edge_n);
    bit got = 0;
    edge_n = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (code_ready) begin got = 1; edge_n = cyc + 1; break; end
    end
    if (!got) chk("accept_timeout", 0, 0, 1);
  endtask

  task automatic send_code(input logic [7:0] c);
    int en;
    @(posedge clk); #1;
    code_in = c; code_valid = 1;
    wait_accept(en);
    @(posedge clk); #1;
    code_valid = 0;
  endtask

  task automatic send_code_wr(input logic [7:0] c, input logic [3:0] a, input logic [79:0] d);
    int en;
    @(posedge clk); #1;
    code_in = c; code_valid = 1;
    wait_accept(en);
    @(posedge clk); #1;
    code_valid = 0;
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [79:0] d);
    @(posedge clk); #1;
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !load_pending && !code_valid) begin done = 1; break; end
    end
    if (!done) chk("idle_timeout", 0, exp_q.size(), 0);
  endtask

  task automatic wait_char();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (char_valid) break;
    end
  endtask

  function automatic logic [79:0] rand_word();
    logic [79:0] w;
    logic [7:0] b;
    for (int i = 0; i < WORD_LEN; i++) begin
      b = 8'($urandom_range(1, 255));
      if ($urandom % 5 == 0) b = 8'h00;
      w[79 - 8*i -: 8] = b;
    end
    return w;
  endfunction

  initial begin
    int e1, e2, h0, w0;
    logic [79:0] speech = "SPEECHPROC";
    logic [79:0] hello  = {"HELLO", 40'h0};
    logic [79:0] neww   = {"NEWWORD1", 16'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_code_ready", code_ready == 1, code_ready, 1);
    chk("rst_char_valid", char_valid == 0, char_valid, 0);
    chk("rst_char_out", char_out == 8'h00, char_out, 0);
    chk("rst_word_end", word_end == 0, word_end, 0);
    chk("rst_busy", busy == 0, busy, 0);
    rst = 0;

    wr(4'd3, speech);
    wr(4'd5, hello);
    rmode = 0;
    send_code(8'h03);
    wait_idle();

    rmode = 1;
    send_code(8'h05);
    wait_idle();

    rmode = 0;
    send_code(8'h10);
    send_code(8'h07);
    wait_idle();

    send_code(8'h05);
    wait_char();
    wr(4'd5, neww);
    wait_idle();
    wr(4'd5, hello);
    send_code_wr(8'h05, 4'd5, neww);
    wait_idle();
    send_code(8'h05);
    wait_idle();

    send_code(8'h03);
    wait_char();
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("async_rst_char_valid", char_valid == 0, char_valid, 0);
    chk("async_rst_code_ready", code_ready == 1, code_ready, 1);
    chk("async_rst_busy", busy == 0, busy, 0);
    chk("async_rst_word_end", word_end == 0, word_end, 0);
    @(posedge clk); #1;
    rst = 0;
    send_code(8'h01);
    wait_idle();

    wr(4'd3, speech);
    wr(4'd5, hello);
    h0 = hs_cnt; w0 = we_cnt;
    @(posedge clk); #1;
    code_in = 8'h03; code_valid = 1;
    wait_accept(e1);
    @(posedge clk); #1;
    code_in = 8'h05;
    wait_accept(e2);
    chk("b2b_accept_gap", e2 == last_hs_edge + 1, e2 - last_hs_edge, 1);
    @(posedge clk); #1;
    code_valid = 0;
    wait_idle();
    chk("b2b_chars", hs_cnt - h0 == 15, hs_cnt - h0, 15);
    chk("b2b_word_ends", we_cnt - w0 == 2, we_cnt - w0, 2);

    rmode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom % 3 == 0) wr(4'($urandom_range(0, 15)), rand_word());
      else send_code(8'($urandom_range(0, 31)));
      if ($urandom % 4 == 0) wait_idle();
    end
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
